imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised, handshaked instruction memory for the single-cycle core's next fetch stage. It replaces the fixed 64-word, combinational-read memory with a synchronous-read memory behind a valid/ready request/response interface. The block adds a two-entry response buffer for back-pressure, a flush input, alignment and range fault reporting, and an optional program-load write port. It sits between the PC/fetch logic and the decode stage.

## Interface

- `DEPTH`, 64: memory size in 32-bit words; must be a power of 2 and at least 2.
- `ADDR_W`, 32: width of the byte PC.
- `NOP_INST`, 32'h00000013: value used to initialise the memory and to fill faulted responses (ADDI x0,x0,0).
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: fetch request valid.
- `req_ready`, out, 1: block can accept a request this cycle.
- `req_pc`, in, ADDR_W: byte address of the instruction to fetch.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_inst`, out, 32: fetched instruction word.
- `rsp_pc`, out, ADDR_W: PC of the request this response belongs to.
- `rsp_fault`, out, 2: bit0 = misaligned (`req_pc[1:0]` != 0); bit1 = out of range (word index >= DEPTH).
- `flush`, in, 1: discard all buffered and in-flight responses.
- `load_en`, in, 1: write `load_data` into the memory (only when IMEM_LOAD_PORT_EN is defined).
- `load_addr`, in, $clog2(DEPTH): word index to write (only when IMEM_LOAD_PORT_EN is defined).
- `load_data`, in, 32: word to write (only when IMEM_LOAD_PORT_EN is defined).

## Operation

- **Storage:** `DEPTH` x 32 array, every word initialised to `NOP_INST` at time zero. Reset does not clear memory contents.
- **Word index:** `req_pc[$clog2(DEPTH)+1:2]`. The range check compares the full `req_pc[ADDR_W-1:2]` against DEPTH.
- **Accept:** a request is accepted when `req_valid && req_ready`. The read happens on that edge, and the result is captured together with `req_pc`.
- **Response buffer:** two entries, FIFO order. The head drives `rsp_*`. A response pops when `rsp_valid && rsp_ready`.
- **req_ready:** equals `!(count==2) && !flush && !load_en && rst_n`. Push and pop in the same cycle at count 1 leaves count unchanged.
- **Faulted request:**
  - It is still accepted and occupies a slot.
  - `rsp_inst` = `NOP_INST`, `rsp_fault` set, and the memory is not read.
  - Both fault bits may be set together.
- **Flush:**
  - Count returns to 0 on the edge.
  - Nothing is accepted that cycle, because `req_ready` is low.
  - `rsp_valid` is low from the next cycle.
  - A pop in the flush cycle is still considered taken by the consumer.
- **Load:**
  - Writes on the edge while `load_en` is high.
  - Fetch is blocked in the same cycle (`req_ready` low), so there is no read/write collision.
  - A later fetch returns the new word.
  - Existing buffered responses are unaffected.

## Timing

- **Reset values:** `rsp_valid` 0, `rsp_inst` 0, `rsp_pc` 0, `rsp_fault` 0, buffer count 0, `req_ready` 0 while `rst_n` is low.
- **Latency:** a request accepted at edge N is visible on `rsp_*` after edge N (one cycle) if the buffer was empty.
- **Throughput:** one request per cycle while `rsp_ready` is held high.
- **Stability:** while `rsp_valid && !rsp_ready`, `rsp_inst`, `rsp_pc` and `rsp_fault` are held stable.
- **Stall:** a third request is refused while two responses are held.
- **Priority:** reset > flush > load > fetch.
- **Reset mid-stream:** reset asserted asynchronously with buffered responses drops them immediately, and `rsp_valid` goes to 0 without waiting for a clock edge.

## Configuration

- **IMEM_LOAD_PORT_EN defined:**
  - `load_en`, `load_addr` and `load_data` ports exist.
  - Writes behave as described under Operation.
  - `req_ready` includes `!load_en`.
- **IMEM_LOAD_PORT_EN undefined:**
  - The load ports are absent.
  - The memory is read-only after initialisation.
  - `req_ready` = `!(count==2) && !flush && rst_n`.

## Test plan

- **Back-to-back stream:** `rsp_ready`=1, fetch pc 0, 4, 8 on consecutive cycles -> `rsp_inst` = NOP x3 one cycle later each, `rsp_pc` 0, 4, 8, `rsp_fault` 0.
- **Back-pressure:** `rsp_ready`=0, requests at pc 0 and 4 accepted, pc 8 refused (`req_ready`=0) -> outputs hold pc 0 stable. Raising `rsp_ready` drains 0 then 4, and pc 8 is accepted in the first cycle `req_ready` is high again.
- **Faults:**
  - pc 0x2 -> `rsp_fault`=2'b01, `rsp_inst`=0x00000013.
  - pc 0x100 with DEPTH=64 -> `rsp_fault`=2'b10.
  - pc 0x102 -> `rsp_fault`=2'b11.
- **Load then fetch (macro defined):** load word 3 with 0x00500113 -> `req_ready`=0 during the load. A subsequent fetch at pc 0xC returns 0x00500113, `rsp_fault` 0.
- **Flush with two buffered responses:** `rsp_valid`=0 on the next cycle, a request in the flush cycle is not accepted, and the next request returns normally.
- **Async reset with a full buffer:** `rsp_valid` drops immediately. After release, a fetch at pc 0 responds in one cycle.

Source files
------------

// File: rtl/imem_fetch_unit_if.sv
// Fetch request/response bus between the PC/fetch logic (master) and the
// instruction memory (slave).
interface imem_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_inst;
    logic [ADDR_W-1:0] rsp_pc;
    logic [1:0]        rsp_fault;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Synchronous-read instruction memory with a two-entry response FIFO, flush and
// fault reporting. Define IMEM_LOAD_PORT_EN to add the program-load write port.
module imem_fetch_unit #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    imem_fetch_unit_if.slave         bus
`ifdef IMEM_LOAD_PORT_EN
    ,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        fault;
    } rsp_t;

    logic [31:0] mem [DEPTH] = '{default: NOP_INST};

    rsp_t       ent [2];
    rsp_t       new_ent;
    logic [1:0] count;
    logic [1:0] base;
    logic       push;
    logic       pop;
    logic       blocked;
    logic       misaligned;
    logic       out_of_range;

`ifdef IMEM_LOAD_PORT_EN
    assign blocked = flush || load_en;

    // Writes are independent of the response path; fetch is held off while loading.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end
`else
    assign blocked = flush;
`endif

    assign bus.req_ready = (count != 2'd2) && !blocked && rst_n;
    assign bus.rsp_valid = (count != 2'd0);
    assign bus.rsp_inst  = ent[0].inst;
    assign bus.rsp_pc    = ent[0].pc;
    assign bus.rsp_fault = ent[0].fault;

    assign push = bus.req_valid && bus.req_ready;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    // Word index >= DEPTH is equivalent to any bit above the index being set.
    assign misaligned   = |bus.req_pc[1:0];
    assign out_of_range = |bus.req_pc[ADDR_W-1:IDX_W+2];

    always_comb begin
        new_ent       = '0;
        new_ent.pc    = bus.req_pc;
        new_ent.fault = {out_of_range, misaligned};
        new_ent.inst  = (misaligned || out_of_range) ? NOP_INST
                                                     : mem[bus.req_pc[IDX_W+1:2]];
    end

    // Slot the new entry lands in once this cycle's pop has been applied.
    assign base = count - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            ent[0] <= '0;
            ent[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop)  ent[0] <= ent[1];
            if (push) ent[base[0]] <= new_ent;
            count <= base + {1'b0, push};
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized + directed check of imem_fetch_unit against a queue-based reference.
module tb_imem_fetch_unit;
    localparam int          DEPTH = 64;
    localparam int          IW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
`ifdef IMEM_LOAD_PORT_EN
    logic          load_en;
    logic [IW-1:0] load_addr;
    logic [31:0]   load_data;
`endif

    imem_fetch_unit_if #(.ADDR_W(32)) bus ();

    imem_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .NOP_INST(NOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus.slave)
`ifdef IMEM_LOAD_PORT_EN
        ,
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errs;
    int    checks;
    exp_t  q[$];
    logic [31:0] mm [DEPTH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = {((pc >> 2) >= DEPTH), (pc % 4 != 0)};
        e.inst  = (e.fault != 2'b00) ? NOP : mm[(pc >> 2) % DEPTH];
        return e;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic rr,
                       input logic fl, input logic ld, input logic [IW-1:0] la,
                       input logic [31:0] ldd);
        logic ld_on;
        logic exp_rdy;
        logic do_pop;
`ifdef IMEM_LOAD_PORT_EN
        ld_on     = ld;
        load_en   = ld;
        load_addr = la;
        load_data = ldd;
`else
        ld_on = 1'b0;
`endif
        bus.req_valid = v;
        bus.req_pc    = pc;
        bus.rsp_ready = rr;
        flush         = fl;
        @(negedge clk);
        exp_rdy = (q.size() < 2) && !fl && !ld_on;
        chk("req_ready", {63'd0, bus.req_ready}, {63'd0, exp_rdy});
        chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rsp_inst",  {32'd0, bus.rsp_inst},  {32'd0, q[0].inst});
            chk("rsp_pc",    {32'd0, bus.rsp_pc},    {32'd0, q[0].pc});
            chk("rsp_fault", {62'd0, bus.rsp_fault}, {62'd0, q[0].fault});
        end
        do_pop = (q.size() != 0) && rr;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(mk(pc));
        end
        if (ld_on) mm[la] = ldd;
        #1;
    endtask

    task automatic req(input logic [31:0] pc, input logic rr);
        cyc(1'b1, pc, rr, 1'b0, 1'b0, '0, 32'd0);
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 32'd0, rr, 1'b0, 1'b0, '0, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;
        errs   = 0;
        checks = 0;
        for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
`endif
        #2;
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_inst",  {32'd0, bus.rsp_inst},  64'd0);
        chk("rst_rsp_pc",    {32'd0, bus.rsp_pc},    64'd0);
        chk("rst_rsp_fault", {62'd0, bus.rsp_fault}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back stream
        req(32'h0, 1'b1); req(32'h4, 1'b1); req(32'h8, 1'b1); idle(1'b1); idle(1'b1);

        // back-pressure: third request refused, drains in order
        req(32'h0, 1'b0); req(32'h4, 1'b0); req(32'h8, 1'b0); req(32'h8, 1'b0);
        req(32'h8, 1'b1); req(32'h8, 1'b1); idle(1'b1); idle(1'b1); idle(1'b1);

        // faults
        req(32'h2, 1'b1); req(32'h100, 1'b1); req(32'h102, 1'b1); idle(1'b1); idle(1'b1);

`ifdef IMEM_LOAD_PORT_EN
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, IW'(3), 32'h0050_0113);
        req(32'hC, 1'b1); idle(1'b1); idle(1'b1);
`endif

        // flush with two buffered
        req(32'h10, 1'b0); req(32'h14, 1'b0);
        cyc(1'b1, 32'h18, 1'b0, 1'b1, 1'b0, '0, 32'd0);
        idle(1'b0); req(32'h1C, 1'b1); idle(1'b1); idle(1'b1);

        // async reset with a full buffer
        req(32'h20, 1'b0); req(32'h24, 1'b0);
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("arst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("arst_rsp_inst",  {32'd0, bus.rsp_inst},  64'd0);
        chk("arst_rsp_pc",    {32'd0, bus.rsp_pc},    64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(32'h0, 1'b1); idle(1'b1); idle(1'b1);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            pc = 32'($urandom_range(0, 79)) * 4;
            if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                IW'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(1'b1); idle(1'b1); idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
